// File: rtl/rtmq_drain_pkg.sv
// Shared types and helpers for the rtmq stack drain engine: FSM state
// encoding, default stack pop latency, and the effective-period clamp.
package rtmq_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  localparam int unsigned POP_LAT_DEF = 2;

  // The period may never be shorter than the stack's pop-to-data latency
  // plus one, otherwise LOAD would capture a stale top-of-stack word.
  function automatic logic [31:0] calc_prd_e(input logic [31:0] prd,
                                             input int unsigned pop_lat);
    logic [31:0] floor_v;
    floor_v = pop_lat + 1;
    return (prd < floor_v) ? floor_v : prd;
  endfunction

endpackage

// File: rtl/rtmq_stack_drain_if.sv
// Sample stream port of the drain engine: valid/ready handshake carrying
// one captured stack word per transfer.
interface rtmq_stack_drain_if #(
  parameter int W_DAT = 32
) ();

  logic [W_DAT-1:0] smp_dat;
  logic             smp_vld;
  logic             smp_rdy;

  modport master (output smp_dat, output smp_vld, input smp_rdy);
  modport slave  (input smp_dat, input smp_vld, output smp_rdy);

endinterface

// File: rtl/rtmq_drain_timer.sv
// Loadable saturating down-counter that paces the drain engine.
// zero is high when the count is 0 at the end of the current cycle.
module rtmq_drain_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Looking one decrement ahead lets WAIT issue LOAD exactly prd_e cycles
  // after the previous LOAD.
  assign zero = (cnt_q <= W'(1));

endmodule

// File: rtl/rtmq_stack_drain.sv
// Timed drain engine: pops cfg_cnt words off the BRAM stack and presents one
// per period on a valid/ready port. Define RTMQ_DRAIN_URUN_EN for underrun detection.
module rtmq_stack_drain
  import rtmq_drain_pkg::*;
#(
  parameter int          W_DAT   = 32,
  parameter int          W_CNT   = 16,
  parameter int          W_PRD   = 16,
  parameter int unsigned POP_LAT = POP_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W_CNT-1:0]         cfg_cnt,
  input  logic [W_PRD-1:0]         cfg_prd,
  input  logic                     start,
  input  logic                     abort,
  input  logic [W_DAT-1:0]         stk_dat,
  output logic                     stk_pop,
  rtmq_stack_drain_if.master       smp,
  output logic                     busy,
  output logic                     done,
  output logic                     urun
);

  state_t           state_q, state_d;
  logic [W_CNT-1:0] rem_q;
  logic [W_PRD-1:0] prd_e_q;
  logic [W_DAT-1:0] dat_q;
  logic             done_q;
  logic             tmr_zero;
  logic             hs;
  logic             start_ok;

  assign hs       = (state_q == ST_PRESENT) && smp.smp_rdy;
  assign start_ok = (state_q == ST_IDLE) && start && !abort;

  rtmq_drain_timer #(.W(W_PRD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q == ST_LOAD),
    .value (prd_e_q - W_PRD'(1)),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start && cfg_cnt != '0) state_d = ST_LOAD;
        ST_LOAD:    state_d = ST_PRESENT;
        ST_PRESENT: if (hs) state_d = (rem_q == '0) ? ST_IDLE : ST_WAIT;
        ST_WAIT:    if (tmr_zero) state_d = ST_LOAD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stk_pop     = 1'b0;
    smp.smp_vld = 1'b0;
    busy        = 1'b0;
    stk_pop     = (state_q == ST_LOAD);
    smp.smp_vld = (state_q == ST_PRESENT);
    busy        = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      prd_e_q <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        rem_q   <= cfg_cnt;
        prd_e_q <= W_PRD'(calc_prd_e(32'(cfg_prd), POP_LAT));
        done_q  <= (cfg_cnt == '0);
      end
      if (state_q == ST_LOAD) begin
        dat_q <= stk_dat;
        rem_q <= rem_q - W_CNT'(1);
      end
      if (hs && rem_q == '0 && !abort) done_q <= 1'b1;
    end
  end

  assign smp.smp_dat = dat_q;
  assign done        = done_q;

`ifdef RTMQ_DRAIN_URUN_EN
  logic urun_q;

  // The sample is late once its slot expires while still unaccepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urun_q <= 1'b0;
    end else if (start_ok) begin
      urun_q <= 1'b0;
    end else if (state_q == ST_PRESENT && !smp.smp_rdy && tmr_zero && !abort) begin
      urun_q <= 1'b1;
    end
  end

  assign urun = urun_q;
`else
  assign urun = 1'b0;
`endif

endmodule

// File: doc/rtmq_stack_drain.md
Name: rtmq_stack_drain

Overview:
- Timed drain engine placed directly downstream of the BRAM stack peripheral.
- Pops a programmed number of words off the stack and captures each top-of-stack word.
- Presents each captured word as one sample on a valid/ready port, one per programmed period, for DDS/DAC playback logic.
- Config inputs are driven by GP registers in the peripheral wrapper; no alu_out decoding happens inside this block.

Parameters:
- W_DAT, 32: stack word / sample width; equals W_REG.
- W_CNT, 16: width of the word-count register.
- W_PRD, 16: width of the period register, in clk cycles.
- POP_LAT, 2: cycles from a stk_pop pulse until stk_dat shows the new top.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cfg_cnt  in  W_CNT  number of words to drain; sampled on start.
- cfg_prd  in  W_PRD  sample period in cycles; sampled on start.
- start  in  1  one-cycle start strobe.
- abort  in  1  one-cycle abort strobe.
- stk_dat  in  W_DAT  stack top-of-stack output.
- stk_pop  out  1  one-cycle pop strobe to the stack.
- smp_dat  out  W_DAT  sample data.
- smp_vld  out  1  sample valid.
- smp_rdy  in  1  consumer ready.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion pulse.
- urun  out  1  sticky underrun flag.

Behaviour:
- Reset (rst_n low, async):
  - state IDLE; all outputs 0, including smp_dat.
  - Internal counters cleared.
- Effective period: prd_e = max(cfg_prd, POP_LAT+1), latched on start. This guarantees stk_dat has settled before the next capture.
- IDLE:
  - start with cfg_cnt != 0: latch rem = cfg_cnt and prd_e; go to LOAD.
  - start with cfg_cnt == 0: done pulses the next cycle; stay in IDLE.
- LOAD (1 cycle):
  - smp_dat <= stk_dat; stk_pop = 1 for this cycle only.
  - rem <= rem - 1; period timer loaded with prd_e - 1.
  - Next state PRESENT with smp_vld = 1.
- PRESENT:
  - smp_vld stays high and smp_dat is stable until the cycle where smp_vld & smp_rdy.
  - The period timer decrements every cycle, saturating at 0.
  - On handshake with rem == 0: smp_vld <= 0, done pulses next cycle, go to IDLE.
  - On handshake with rem > 0: smp_vld <= 0, go to WAIT.
- WAIT:
  - When the timer reaches 0, go to LOAD.
  - A timer already at 0 on entry gives LOAD the next cycle.
- Sample spacing: with smp_rdy held high, LOAD-to-LOAD spacing is exactly prd_e cycles.
- Underrun (urun sticky):
  - Set when the timer reaches 0 while in PRESENT without a handshake. The sample is held, never dropped.
  - The next LOAD occurs the cycle after the WAIT entry that follows the late handshake. Spacing stretches; it never shrinks below POP_LAT+1.
  - urun is cleared only by start or reset.
- abort (any state, priority over everything):
  - Next cycle: state IDLE, smp_vld = 0, busy = 0.
  - No further pops; a pop already issued is not retracted.
  - done is not pulsed.
- Ignored inputs:
  - start while busy is ignored.
  - start and abort in the same IDLE cycle: abort wins, start is ignored.
- busy = (state != IDLE).
- Stack occupancy is not visible to this block. Software must not program cfg_cnt above the stack fill level; popping an empty stack returns undefined data and is not flagged.
- Arithmetic: rem and timer are unsigned and never wrap (the guards above prevent it).

Optional Feature:
- Macro: RTMQ_DRAIN_URUN_EN.
- Defined: underrun detection as specified above.
- Undefined: urun is tied 0 and the detection logic is omitted. Spacing behaviour is unchanged; samples are still held, never dropped.

Decomposition:
- Shared package/include rtmq_drain_pkg holds:
  - state encoding IDLE/LOAD/PRESENT/WAIT (2-bit);
  - default POP_LAT = 2;
  - a function computing prd_e.
- One sub-module, rtmq_drain_timer:
  - loadable saturating down-counter;
  - ports: load, value, zero flag.
- The FSM and datapath stay in the top module.

Test Plan:
- Stack preloaded 5,6,7 (top = 7); cfg_cnt = 3, cfg_prd = 10, smp_rdy = 1, start → samples 7,6,5 at LOAD spacing 10 cycles; 3 pops; done pulses once; urun = 0.
- cfg_prd = 1, cfg_cnt = 2 → spacing clamped to 3 cycles; second sample equals the new top after pop.
- smp_rdy held low for 15 cycles on sample 1 with cfg_prd = 8 → smp_dat stable and no pop during the stall; urun = 1 (0 with the macro undefined); next LOAD 1 cycle after WAIT entry.
- cfg_cnt = 0, start → done pulse, no stk_pop, busy stays 0.
- abort in WAIT after 1 of 4 samples → busy = 0 next cycle, exactly 1 pop total, no done; a new start runs normally and clears urun.
- rst_n low mid-PRESENT → smp_vld, stk_pop, busy, urun = 0 immediately (asynchronous); state IDLE after release.
